custom_axi_ip_engine: RTL and testbench

- Parametrised job engine behind the register-to-hardware interface. It accepts commands through a valid/ready port into a small command FIFO.
- For each command it runs an iterated arithmetic operation: increment, saturating increment, or checked decrement.
- Each result, with an error flag, is returned on a valid/ready result port.
- Exposes FSM state (status_e) and a completed-job counter for the status register.

---
 rtl/custom_axi_ip_pkg.sv | 28 ++
 rtl/custom_axi_ip_cmd_fifo.sv | 43 ++++
 rtl/custom_axi_ip_engine.sv | 138 +++++++++++++
 tb/tb_custom_axi_ip_engine.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the custom AXI IP job engine: FSM status, operation modes
// and the command record layout used at the default widths.
package custom_axi_ip_pkg;

  localparam int unsigned CMD_DATA_W = 32;
  localparam int unsigned CMD_ITER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    MODE_INC     = 2'd0,
    MODE_INC_SAT = 2'd1,
    MODE_DEC     = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_ITER_W-1:0] iter;
    mode_e                 mode;
  } cmd_t;

endpackage

// File: rtl/custom_axi_ip_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB so full and empty
// can be told apart when the index bits match.
module custom_axi_ip_cmd_fifo
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wptr_q <= wptr_q + PTR_ONE;
      if (pop_i  && !empty_o) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/custom_axi_ip_engine.sv
// Job engine: pops queued commands, iterates the selected arithmetic op and
// returns each result with an error flag over a valid/ready port.
module custom_axi_ip_engine
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ITER_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned JOBCNT_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]   cmd_data_i,
  input  logic [ITER_WIDTH-1:0]   cmd_iter_i,
  input  mode_e                   cmd_mode_i,
  input  logic                    abort_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [DATA_WIDTH-1:0]   res_data_o,
  output logic                    res_err_o,
  output status_e                 status_o,
  output logic [JOBCNT_WIDTH-1:0] jobs_done_o
);

  localparam int unsigned CMD_W = DATA_WIDTH + ITER_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0]   DATA_ONE = 1;
  localparam logic [ITER_WIDTH-1:0]   ITER_ONE = 1;
  localparam logic [JOBCNT_WIDTH-1:0] JOB_ONE  = 1;

  logic [CMD_W-1:0]      push_word, head_word;
  logic                  fifo_full, fifo_empty, pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ITER_WIDTH-1:0] head_iter;
  mode_e                 head_mode;

  status_e                 state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [ITER_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [JOBCNT_WIDTH-1:0] jobs_q, jobs_d;

  assign push_word = {cmd_data_i, cmd_iter_i, cmd_mode_i};
  assign head_data = head_word[CMD_W-1 -: DATA_WIDTH];
  assign head_iter = head_word[2 +: ITER_WIDTH];
  assign head_mode = mode_e'(head_word[1:0]);

  custom_axi_ip_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= MODE_INC;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    jobs_d  = jobs_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          acc_d   = head_data;
          cnt_d   = head_iter;
          mode_d  = head_mode;
          err_d   = 1'b0;
          state_d = (head_iter != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (abort_i) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else if ((mode_q == MODE_RSVD) || (mode_q == MODE_DEC && acc_q == '0)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          // err_q doubles as the sticky saturation flag until the job ends
          case (mode_q)
            MODE_INC_SAT: begin
              if (acc_q == '1) err_d = 1'b1;
              else             acc_d = acc_q + DATA_ONE;
            end
            MODE_DEC: acc_d = acc_q - DATA_ONE;
            default:  acc_d = acc_q + DATA_ONE;
          endcase
          cnt_d = cnt_q - ITER_ONE;
          if (cnt_q == ITER_ONE) state_d = DONE;
        end
      end
      default: begin
        if (res_ready_i) begin
          state_d = IDLE;
          jobs_d  = jobs_q + JOB_ONE;
        end
      end
    endcase
  end

  assign cmd_ready_o = !fifo_full;
  assign res_valid_o = (state_q == DONE) || (state_q == ERROR);
  assign res_data_o  = acc_q;
  assign res_err_o   = err_q;
  assign status_o    = state_q;
  assign jobs_done_o = jobs_q;

endmodule

// File: tb/tb_custom_axi_ip_engine.sv
// Self-checking bench: directed scenarios plus randomized traffic scored
// against an arithmetic reference model of each job.
module tb_custom_axi_ip_engine;
  import custom_axi_ip_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned JW = 16;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, abort, res_valid, res_ready, res_err;
  logic [DW-1:0] cmd_data, res_data;
  logic [IW-1:0] cmd_iter;
  mode_e         cmd_mode;
  status_e       status;
  logic [JW-1:0] jobs_done;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    status_e       st;
  } exp_t;

  exp_t          sb[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_mis = 0;
  logic [JW-1:0] exp_jobs;

  custom_axi_ip_engine #(
    .DATA_WIDTH   (DW),
    .ITER_WIDTH   (IW),
    .FIFO_DEPTH   (4),
    .JOBCNT_WIDTH (JW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_data_i  (cmd_data),
    .cmd_iter_i  (cmd_iter),
    .cmd_mode_i  (cmd_mode),
    .abort_i     (abort),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_err_o   (res_err),
    .status_o    (status),
    .jobs_done_o (jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result of a job: abort_at is the step index on which abort is seen (-1 none)
  function automatic exp_t model(input logic [DW-1:0] data, input int iter,
                                 input mode_e mode, input int abort_at);
    exp_t          r;
    logic [DW-1:0] acc;
    logic          sat;
    acc = data;
    sat = 1'b0;
    for (int i = 0; i < iter; i++) begin
      if (i == abort_at || mode == MODE_RSVD || (mode == MODE_DEC && acc == 0)) begin
        r.data = acc; r.err = 1'b1; r.st = ERROR;
        return r;
      end
      if (mode == MODE_DEC) acc = acc - 1;
      else if (mode == MODE_INC_SAT && acc == {DW{1'b1}}) sat = 1'b1;
      else acc = acc + 1;
    end
    r.data = acc; r.err = sat; r.st = DONE;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [DW-1:0] d, input int iter, input mode_e m,
                          input int abort_at);
    int unsigned w;
    w = 0;
    cmd_data  = d;
    cmd_iter  = iter[IW-1:0];
    cmd_mode  = m;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 1000) begin
      step();
      w++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    sb.push_back(model(d, iter, m, abort_at));
  endtask

  task automatic collect(input string tag, input bit rand_ready, output int unsigned waited);
    exp_t e;
    waited = 0;
    while (1) begin
      res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if ((res_valid && res_ready) || waited >= 2000) break;
      step();
      waited++;
    end
    if (!(res_valid && res_ready)) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      res_ready = 1'b0;
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 64'd1, 64'd0);
      e.data = '0; e.err = 1'b0; e.st = DONE;
    end else begin
      e = sb.pop_front();
    end
    check({tag, "_data"}, res_data, e.data);
    check({tag, "_err"}, res_err, e.err);
    check({tag, "_status"}, status, e.st);
    step();
    res_ready = 1'b0;
    exp_jobs++;
    check({tag, "_jobs"}, jobs_done, exp_jobs);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] ones;
    ones = '1;
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return 1;
      2:       return ones;
      3:       return ones - 1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int unsigned lat, vcnt;
    cmd_valid = 1'b0; cmd_data = '0; cmd_iter = '0; cmd_mode = MODE_INC;
    abort = 1'b0; res_ready = 1'b0; exp_jobs = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_status", status, IDLE);
    check("rst_jobs", jobs_done, 0);
    rst_n = 1'b1;
    step();

    push_cmd(32'd5, 3, MODE_INC, -1);
    collect("inc_basic", 1'b0, lat);
    check("inc_basic_latency", lat, 4);

    push_cmd(32'hFFFF_FFFE, 4, MODE_INC_SAT, -1);
    collect("inc_sat", 1'b0, lat);
    push_cmd(32'hFFFF_FFFE, 4, MODE_INC, -1);
    collect("inc_wrap", 1'b0, lat);

    push_cmd(32'd2, 5, MODE_DEC, -1);
    collect("dec_underflow", 1'b0, lat);
    check("dec_underflow_latency", lat, 4);
    push_cmd(32'd7, 0, MODE_INC, -1);
    collect("iter_zero", 1'b0, lat);
    check("iter_zero_latency", lat, 1);
    push_cmd(32'd9, 3, MODE_RSVD, -1);
    collect("rsvd", 1'b0, lat);

    // Fill the FIFO behind a stalled result
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(32'(i * 3 + 1), 2, MODE_INC, -1);
    check("fifo_full_ready", cmd_ready, 0);
    for (int i = 0; i < 5; i++) collect("fifo_drain", 1'b0, lat);

    push_cmd(32'd100, 50, MODE_INC, 9);
    vcnt = 0;
    while (status != BUSY && vcnt < 100) begin
      step();
      vcnt++;
    end
    repeat (9) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    collect("abort", 1'b0, lat);

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) step();
          push_cmd(rand_data(), int'($urandom_range(0, 12)),
                   mode_e'($urandom_range(0, 3)), -1);
        end
      end
      begin
        int unsigned w;
        for (int i = 0; i < 30; i++) collect("rand", 1'b1, w);
      end
    join

    res_ready = 1'b0;
    push_cmd(32'd0, 200, MODE_INC, -1);
    push_cmd(32'd1, 5, MODE_INC, -1);
    push_cmd(32'd2, 5, MODE_DEC, -1);
    repeat (5) step();
    check("midjob_status", status, BUSY);
    rst_n = 1'b0;
    #2;
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_res_err", res_err, 0);
    check("midrst_status", status, IDLE);
    check("midrst_jobs", jobs_done, 0);
    sb.delete();
    exp_jobs = '0;
    step();
    rst_n = 1'b1;
    res_ready = 1'b1;
    vcnt = 0;
    repeat (30) begin
      step();
      if (res_valid) vcnt++;
    end
    check("postrst_no_results", vcnt, 0);
    check("postrst_status", status, IDLE);
    check("postrst_jobs", jobs_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
